// File: rtl/ofmaps_tx_pkg.sv
// Shared types and helpers for the ofmaps AXI-Stream transmit path.
// FSM encoding plus a constant log2 helper for pointer/lane widths.
package ofmaps_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ofmaps_tx_fifo.sv
// Small synchronous word FIFO with count, flags and flush.
// Storage is cleared on reset so the head reads zero out of reset.
module ofmaps_tx_fifo
  import ofmaps_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = clogb2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_ofmaps_tx.sv
// AXI4-Stream master returning ofmaps: buffers packed words and
// serializes each into PACK beats, with TLAST at the frame end.
module axis_ofmaps_tx
  import ofmaps_tx_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned PACK                 = 4,
  parameter int unsigned FIFO_DEPTH           = 4,
  parameter int unsigned LEN_WIDTH            = 16,
  parameter int unsigned IN_WIDTH = PACK * C_M_AXIS_TDATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IN_WIDTH-1:0]               in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LEN_WIDTH-1:0]              frame_len,
  input  logic                              start,
  input  logic                              clear,
  output logic                              busy,
  output logic                              done,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY
);

  localparam int W      = C_M_AXIS_TDATA_WIDTH;
  localparam int LANE_W = (PACK > 1) ? clogb2(PACK) : 1;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_q;
  logic [LANE_W-1:0]    lane_q;
  logic                 busy_q;
  logic                 done_q;

  logic [IN_WIDTH-1:0]  head;
  logic                 hs;
  logic                 last;
  logic                 pop;
  logic                 push;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  ofmaps_tx_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (clear),
    .push_i  (push),
    .data_i  (in_data),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TVALID = busy_q & ~fifo_empty;
  assign M_AXIS_TLAST  = last;

  assign last = busy_q & (beat_q == len_q - LEN_WIDTH'(1));
  assign hs   = M_AXIS_TVALID & M_AXIS_TREADY;
  // Final beat pops the head too, dropping its unsent lanes.
  assign pop  = hs & ((lane_q == LANE_W'(PACK - 1)) | last);

  always_comb begin
    M_AXIS_TDATA = '0;
    for (int i = 0; i < int'(PACK); i++) begin
      if (lane_q == LANE_W'(i)) begin
        M_AXIS_TDATA = head[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      lane_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (frame_len != '0) begin
              len_q   <= frame_len;
              beat_q  <= '0;
              lane_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= SEND;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        SEND: begin
          if (hs) begin
            beat_q <= beat_q + 1'b1;
            lane_q <= pop ? '0 : lane_q + 1'b1;
            if (last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ofmaps_tx.sv
// Directed bench for axis_ofmaps_tx with hand-computed beat values.
// Inputs change #1 after the rising edge; outputs are checked then.
module tb_axis_ofmaps_tx;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  frame_len;
  logic         start;
  logic         clear;
  logic         busy;
  logic         done;
  logic         fifo_empty;
  logic         fifo_full;
  logic [31:0]  tdata;
  logic [3:0]   tstrb;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  int nvec = 0;
  int nerr = 0;

  localparam logic [127:0] W1 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] W2 = {32'd8, 32'd7, 32'd6, 32'd5};
  localparam logic [127:0] W3 = {32'd12, 32'd11, 32'd10, 32'd9};
  localparam logic [127:0] W4 = {32'd16, 32'd15, 32'd14, 32'd13};

  axis_ofmaps_tx dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .frame_len     (frame_len),
    .start         (start),
    .clear         (clear),
    .busy          (busy),
    .done          (done),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [127:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic go(input logic [15:0] n);
    frame_len = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Expects n beats with TREADY high, values first..first+n-1.
  task automatic beats(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_v%0d", tag, i), 32'(tvalid), 32'd1);
      chk($sformatf("%s_d%0d", tag, i), tdata, 32'(first + i));
      chk($sformatf("%s_l%0d", tag, i), 32'(tlast), 32'(i == n - 1));
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    int cyc;
    logic [3:0] pat;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    frame_len = '0;
    start     = 1'b0;
    clear     = 1'b0;
    tready    = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_tstrb", 32'(tstrb), 32'hf);
    rst = 1'b0;
    tick();

    // 8-beat frame over two words
    push(W1);
    push(W2);
    tready = 1'b1;
    go(16'd8);
    beats("f8", 1, 8);
    tick();
    chk("f8_done_off", 32'(done), 32'd0);
    chk("f8_empty", 32'(fifo_empty), 32'd1);

    // 6-beat frame drops lanes 2..3 of word 2
    push(W1);
    push(W2);
    go(16'd6);
    beats("f6", 1, 6);
    chk("f6_empty", 32'(fifo_empty), 32'd1);
    tick();

    // stalls: TREADY pattern 1,0,0,1
    push(W1);
    tready = 1'b0;
    go(16'd4);
    pat = 4'b1001;
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 20) begin
      tready = pat[3 - (cyc % 4)];
      chk($sformatf("st_v%0d", cyc), 32'(tvalid), 32'd1);
      chk($sformatf("st_d%0d", cyc), tdata, 32'(k + 1));
      chk($sformatf("st_l%0d", cyc), 32'(tlast), 32'(k == 3));
      if (tready) k++;
      cyc++;
      tick();
    end
    chk("st_beats", 32'(k), 32'd4);
    chk("st_done", 32'(done), 32'd1);
    tready = 1'b1;
    tick();

    // fill FIFO, refused push during pop, 16-beat frame
    push(W1);
    push(W2);
    push(W3);
    push(W4);
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_inrdy", 32'(in_ready), 32'd0);
    chk("fill_idle", 32'(tvalid), 32'd0);
    go(16'd16);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fl_d%0d", i), tdata, 32'(i + 1));
      tick();
    end
    in_valid = 1'b1;
    in_data  = {4{32'hdead_beef}};
    chk("fl_inrdy_pop", 32'(in_ready), 32'd0);
    chk("fl_d3", tdata, 32'd4);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk("fl_after_pop", 32'(fifo_full), 32'd0);
    beats("fl", 5, 12);
    chk("fl_empty", 32'(fifo_empty), 32'd1);
    tick();

    // zero-length frame
    go(16'd0);
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_tvalid", 32'(tvalid), 32'd0);
    tick();
    chk("z_done_off", 32'(done), 32'd0);
    chk("z_tvalid2", 32'(tvalid), 32'd0);

    // start during SEND ignored
    push(W1);
    go(16'd4);
    chk("ig_d0", tdata, 32'd1);
    tick();
    frame_len = 16'd7;
    start     = 1'b1;
    chk("ig_d1", tdata, 32'd2);
    tick();
    start = 1'b0;
    beats("ig", 3, 2);
    tick();

    // clear mid-frame, then a clean frame from lane 0
    push(W1);
    push(W2);
    go(16'd8);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cl_d%0d", i), tdata, 32'(i + 1));
      tick();
    end
    tready = 1'b0;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    chk("cl_busy", 32'(busy), 32'd0);
    chk("cl_empty", 32'(fifo_empty), 32'd1);
    chk("cl_tvalid", 32'(tvalid), 32'd0);
    chk("cl_done", 32'(done), 32'd0);
    chk("cl_tlast", 32'(tlast), 32'd0);
    push(W2);
    tready = 1'b1;
    go(16'd4);
    beats("cl4", 5, 4);
    chk("cl4_empty", 32'(fifo_empty), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axis_ofmaps_tx.md
# axis_ofmaps_tx

AXI4-Stream master that returns output feature maps to the host, the transmit-side counterpart of the ifmaps AXI-Stream slave path in `data_path`. It accepts packed result words from the psum/ofmaps side via a valid/ready handshake and buffers them in a small FIFO. It then serializes each word into `PACK` 32-bit beats on `M_AXIS_*`, asserting TLAST on the final beat of a frame whose length was programmed at `start`.

## Interface
- `C_M_AXIS_TDATA_WIDTH`, 32, output beat width
- `PACK`, 4, lanes (beats) per input word; `IN_WIDTH = PACK*C_M_AXIS_TDATA_WIDTH`
- `FIFO_DEPTH`, 4, input-word FIFO depth (power of 2, ≥2)
- `LEN_WIDTH`, 16, width of the frame beat count
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  IN_WIDTH  packed result word; lane 0 = bits [31:0]
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  `~fifo_full`
- `frame_len`  in  LEN_WIDTH  beats in next frame; sampled on accepted `start`
- `start`  in  1  single-cycle frame start pulse
- `clear`  in  1  flush FIFO, lane index and FSM; highest priority after `rst`
- `busy`  out  1  FSM in SEND
- `done`  out  1  one-cycle pulse, FSM in DONE
- `fifo_empty`, `fifo_full`  out  1  FIFO status
- `M_AXIS_TDATA`  out  32  current lane of FIFO head
- `M_AXIS_TSTRB`  out  4  constant all-ones
- `M_AXIS_TLAST`  out  1  final beat of frame
- `M_AXIS_TVALID`  out  1  `busy & ~fifo_empty`
- `M_AXIS_TREADY`  in  1  downstream ready

## Operation
- FSM states: IDLE, SEND, DONE. `rst` or `clear` → IDLE, FIFO count 0, `lane_idx` 0, `beat_cnt` 0.
- IDLE: `start` with `frame_len`≠0 latches `frame_len`, clears `beat_cnt`, → SEND. With `frame_len`=0 → DONE without emitting any beat. `start` in SEND/DONE is ignored.
- FIFO writes are allowed in any state. A word is pushed when `in_valid & in_ready`. `in_ready` depends on the current count only, so a push is refused when full even if a pop occurs in the same cycle.
- Beat handshake is `TVALID & TREADY`. On a handshake, `beat_cnt++` and `lane_idx++`. When `lane_idx` = PACK-1, or the beat is the last one, the head is popped and `lane_idx` returns to 0.
- `TLAST = busy & (beat_cnt == len_q-1)`. The handshake on that beat → DONE. Unsent lanes of the final word are discarded by the pop.
- DONE → IDLE unconditionally after one cycle.
- TDATA/TLAST stay stable while `TVALID & ~TREADY`: head and `lane_idx` change only on a handshake.
- `clear` during SEND drops the frame without TLAST. This protocol break is intended and is used only for error recovery.
- Reset values: `busy`=0, `done`=0, `TVALID`=0, `TLAST`=0, `TDATA`=0 (FIFO storage reset to 0), `fifo_empty`=1, `fifo_full`=0, `in_ready`=1.

## Timing
- Input accepted at edge t → `fifo_empty`=0 at t+1 → `TVALID` at t+1 if in SEND. Latency is one cycle, with no bubble.
- Back-to-back: with `TREADY` held high and the FIFO not starved, one beat per cycle, including across word boundaries. The pop and the next word's lane 0 are presented in consecutive cycles.
- `start` at edge t → `busy` at t+1. For `frame_len`=0, `done` at t+1.
- Last handshake at edge e → `busy`=0, `done`=1 during [e, e+1), then IDLE.
- `TVALID` may deassert mid-frame only when the FIFO runs empty. It never deasserts with a beat pending once the FIFO is non-empty.
- `beat_cnt` width is LEN_WIDTH; maximum frame is 2^LEN_WIDTH−1 beats.

## Structure
- Shared package `ofmaps_tx_pkg`: FSM state encoding (IDLE=2'd0, SEND=2'd1, DONE=2'd2) and the `clogb2` function used for pointer and lane widths.
- Sub-module `ofmaps_tx_fifo`: synchronous FIFO with registered storage and a count, plus empty/full flags and flush, reset by `rst`. The top level holds the FSM, lane/beat counters and lane mux. Target is about 250 lines in total.

## Test plan
- Reset, then push words 0x..04_03_02_01 (lanes 1–4) and 0x..08_07_06_05, `frame_len`=8, TREADY=1 → TDATA 1..8 on 8 consecutive cycles, TLAST on 8th only, `done` next cycle.
- `frame_len`=6, two words pushed, TREADY=1 → 6 beats, TLAST on lane 1 of word 2, FIFO empty afterward (lanes 2–3 discarded).
- TREADY toggling 1,0,0,1,… during `frame_len`=4 → TDATA/TLAST stable while stalled, exactly 4 handshakes, values 1..4.
- Fill FIFO to 4 words with no start → `in_ready`=0, `fifo_full`=1. Push attempt during a pop cycle is refused. Word count is preserved and the data order is intact after a 16-beat frame.
- `frame_len`=0 `start` → `done` one cycle later, TVALID never asserted. `start` during SEND is ignored.
- `clear` mid-frame after 3 beats → next cycle IDLE, `fifo_empty`=1, TVALID=0. A new 4-beat frame then runs correctly from lane 0.
